// File: rtl/mips_isa_pkg.sv
// Shared MIPS encoding constants: symbolic op numbers, primary opcodes, funct codes,
// fixed REGIMM rt selectors, the loader state type and word-assembly helpers.
package mips_isa_pkg;

  // Symbolic op numbers as presented on InOp; 30 and 31 are unassigned.
  localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4,  OP_NOR  = 5'd5,  OP_SLT  = 5'd6,  OP_SLL  = 5'd7;
  localparam logic [4:0] OP_SRL  = 5'd8,  OP_JR   = 5'd9,  OP_MUL  = 5'd10, OP_LW   = 5'd11;
  localparam logic [4:0] OP_LB   = 5'd12, OP_LH   = 5'd13, OP_SW   = 5'd14, OP_SB   = 5'd15;
  localparam logic [4:0] OP_SH   = 5'd16, OP_ADDI = 5'd17, OP_ANDI = 5'd18, OP_ORI  = 5'd19;
  localparam logic [4:0] OP_XORI = 5'd20, OP_SLTI = 5'd21, OP_BEQ  = 5'd22, OP_BNE  = 5'd23;
  localparam logic [4:0] OP_BGEZ = 5'd24, OP_BLTZ = 5'd25, OP_BGTZ = 5'd26, OP_BLEZ = 5'd27;
  localparam logic [4:0] OP_J    = 5'd28, OP_JAL  = 5'd29;

  localparam logic [5:0] OPC_RTYPE = 6'h00, OPC_REGIMM = 6'h01, OPC_J    = 6'h02, OPC_JAL  = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04, OPC_BNE    = 6'h05, OPC_BLEZ = 6'h06, OPC_BGTZ = 6'h07;
  localparam logic [5:0] OPC_ADDI  = 6'h08, OPC_SLTI   = 6'h0A, OPC_ANDI = 6'h0C, OPC_ORI  = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E, OPC_SPEC2  = 6'h1C, OPC_LB   = 6'h20, OPC_LH   = 6'h21;
  localparam logic [5:0] OPC_LW    = 6'h23, OPC_SB     = 6'h28, OPC_SH   = 6'h29, OPC_SW   = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR  = 6'h08, FN_MUL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2A;

  localparam logic [4:0] RT_BGEZ = 5'b00001, RT_BLTZ = 5'b00000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } load_state_e;

  function automatic logic [31:0] r_word(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] sh, input logic [5:0] fn);
    return {opc, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational encoder: symbolic op plus operand fields into a 32-bit MIPS word.
// Unassigned op numbers produce a zero word with illegal_o raised.
module instr_field_pack
  import mips_isa_pkg::*;
(
  input  logic [4:0]  op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [25:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (op_i)
      OP_ADD:  word_o = r_word(OPC_RTYPE, rs_i, rt_i, rd_i, 5'd0, FN_ADD);
      OP_SUB:  word_o = r_word(OPC_RTYPE, rs_i, rt_i, rd_i, 5'd0, FN_SUB);
      OP_AND:  word_o = r_word(OPC_RTYPE, rs_i, rt_i, rd_i, 5'd0, FN_AND);
      OP_OR:   word_o = r_word(OPC_RTYPE, rs_i, rt_i, rd_i, 5'd0, FN_OR);
      OP_XOR:  word_o = r_word(OPC_RTYPE, rs_i, rt_i, rd_i, 5'd0, FN_XOR);
      OP_NOR:  word_o = r_word(OPC_RTYPE, rs_i, rt_i, rd_i, 5'd0, FN_NOR);
      OP_SLT:  word_o = r_word(OPC_RTYPE, rs_i, rt_i, rd_i, 5'd0, FN_SLT);
      // Shifts take their source from rt; rs is architecturally zero.
      OP_SLL:  word_o = r_word(OPC_RTYPE, 5'd0, rt_i, rd_i, shamt_i, FN_SLL);
      OP_SRL:  word_o = r_word(OPC_RTYPE, 5'd0, rt_i, rd_i, shamt_i, FN_SRL);
      OP_JR:   word_o = r_word(OPC_RTYPE, rs_i, 5'd0, 5'd0, 5'd0, FN_JR);
      OP_MUL:  word_o = r_word(OPC_SPEC2, rs_i, rt_i, rd_i, 5'd0, FN_MUL);
      OP_LW:   word_o = i_word(OPC_LW,   rs_i, rt_i, imm_i[15:0]);
      OP_LB:   word_o = i_word(OPC_LB,   rs_i, rt_i, imm_i[15:0]);
      OP_LH:   word_o = i_word(OPC_LH,   rs_i, rt_i, imm_i[15:0]);
      OP_SW:   word_o = i_word(OPC_SW,   rs_i, rt_i, imm_i[15:0]);
      OP_SB:   word_o = i_word(OPC_SB,   rs_i, rt_i, imm_i[15:0]);
      OP_SH:   word_o = i_word(OPC_SH,   rs_i, rt_i, imm_i[15:0]);
      OP_ADDI: word_o = i_word(OPC_ADDI, rs_i, rt_i, imm_i[15:0]);
      OP_ANDI: word_o = i_word(OPC_ANDI, rs_i, rt_i, imm_i[15:0]);
      OP_ORI:  word_o = i_word(OPC_ORI,  rs_i, rt_i, imm_i[15:0]);
      OP_XORI: word_o = i_word(OPC_XORI, rs_i, rt_i, imm_i[15:0]);
      OP_SLTI: word_o = i_word(OPC_SLTI, rs_i, rt_i, imm_i[15:0]);
      OP_BEQ:  word_o = i_word(OPC_BEQ,  rs_i, rt_i, imm_i[15:0]);
      OP_BNE:  word_o = i_word(OPC_BNE,  rs_i, rt_i, imm_i[15:0]);
      OP_BGEZ: word_o = i_word(OPC_REGIMM, rs_i, RT_BGEZ, imm_i[15:0]);
      OP_BLTZ: word_o = i_word(OPC_REGIMM, rs_i, RT_BLTZ, imm_i[15:0]);
      OP_BGTZ: word_o = i_word(OPC_BGTZ, rs_i, 5'd0, imm_i[15:0]);
      OP_BLEZ: word_o = i_word(OPC_BLEZ, rs_i, 5'd0, imm_i[15:0]);
      OP_J:    word_o = {OPC_J,   imm_i};
      OP_JAL:  word_o = {OPC_JAL, imm_i};
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Program-load back end: accepts symbolic instructions, encodes them and writes them to
// sequential instruction-memory words. Define ILLEGAL_OP_TRAP_EN to trap unassigned ops.
module instr_encode_loader
  import mips_isa_pkg::*;
#(
  parameter int          DEPTH     = 128,
  parameter int          ADDR_W    = 32,
  parameter int unsigned BASE_ADDR = 0,
  localparam int         CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Finish,
  input  logic              InValid,
  output logic              InReady,
  input  logic [4:0]        InOp,
  input  logic [4:0]        InRs,
  input  logic [4:0]        InRt,
  input  logic [4:0]        InRd,
  input  logic [4:0]        InShamt,
  input  logic [25:0]       InImm,
  output logic              WrEn,
  output logic [ADDR_W-1:0] WrAddr,
  output logic [31:0]       WrData,
  output logic              Busy,
  output logic              Full,
  output logic              Done,
  output logic [CNT_W-1:0]  WordCount,
  output logic              Error,
  output logic [1:0]        DbgState
);

  // Handshake: a word transfers on a rising edge where InValid and InReady are both high;
  // InReady never depends on InValid, and InValid may be held until the transfer happens.

  load_state_e       state_q, state_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       enc_word;
  logic              enc_illegal;
  logic              accept;
  logic              do_write;

  instr_field_pack u_pack (
    .op_i      (InOp),
    .rs_i      (InRs),
    .rt_i      (InRt),
    .rd_i      (InRd),
    .shamt_i   (InShamt),
    .imm_i     (InImm),
    .word_o    (enc_word),
    .illegal_o (enc_illegal)
  );

  assign InReady = (state_q == ST_LOAD) & ~Start & ~Finish;
  assign accept  = InValid & InReady;

`ifdef ILLEGAL_OP_TRAP_EN
  assign do_write = ~enc_illegal;
`else
  assign do_write = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    count_d   = count_q;
    done_d    = 1'b0;
    err_d     = err_q;
    if (Start) begin
      state_d   = ST_LOAD;
      count_d   = '0;
      wr_addr_d = ADDR_W'(BASE_ADDR);
      err_d     = 1'b0;
    end else if (Finish && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      done_d  = 1'b1;
    end else if (accept) begin
      if (do_write) begin
        wr_en_d   = 1'b1;
        // Untrapped illegal ops land in memory as a nop.
        wr_data_d = enc_illegal ? 32'h0 : enc_word;
        wr_addr_d = ADDR_W'(BASE_ADDR) + (ADDR_W'(count_q) << 2);
        count_d   = count_q + CNT_W'(1);
        if (count_d == CNT_W'(DEPTH)) state_d = ST_FULL;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= ADDR_W'(BASE_ADDR);
      wr_data_q <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      count_q   <= count_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign WrEn      = wr_en_q;
  assign WrAddr    = wr_addr_q;
  assign WrData    = wr_data_q;
  assign Busy      = (state_q != ST_IDLE);
  assign Full      = (state_q == ST_FULL);
  assign Done      = done_q;
  assign WordCount = count_q;
  assign Error     = err_q;
  assign DbgState  = state_q;

endmodule
